uart_rx_param: RTL

UART_RX_PARAM -- requirements
Module: uart_rx_param

---
 rtl/uart_rx_param.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_param.sv
// Purpose: parameterised UART receiver with 2-of-3 mid-bit voting, optional parity, 1/2 stop bits.
// Latency: result pulses one cycle in DONE, about P/2+3 CLK after the final stop bit begins.
// Backpressure: none; result pulses last one cycle and must be taken when they appear.
// Optional break detection is enabled by defining UART_RX_BREAK_EN.
module uart_rx_param #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  S_Data,
    input  logic                  Parity_EN,
    input  logic                  Parity_type,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic [3:0]            Data_len,
    input  logic                  Stop_bits,
    output logic [DATA_WIDTH-1:0] P_Data,
    output logic                  Data_valid,
    output logic                  Parity_error,
    output logic                  stop_error,
    output logic                  Break
);

`ifdef UART_RX_BREAK_EN
    localparam bit BREAK_EN = 1'b1;
`else
    localparam bit BREAK_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;

    state_t                  state, next_state;
    logic                    sync1, sync2;
    logic [1:0]              fill;
    logic                    armed;
    logic [PRESCALE_W-1:0]   cnt, ps_lat, ps_even, ps_eff, half;
    logic [3:0]              dl_lat, dl_eff, bit_idx;
    logic                    pen_lat, ptype_lat, stop2_lat, stop_idx;
    logic                    samp_a, samp_b, maj;
    logic [DATA_WIDTH-1:0]   data_sr;
    logic                    par_acc, perr, serr, all_zero;
    logic                    start_det, at_a, at_b, at_maj, bit_end, last_data, last_stop, fin;

    // Two-flop synchronizer, idle-high; fill marks when sync2 reflects the real line.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            fill  <= 2'd0;
        end else begin
            sync1 <= S_Data;
            sync2 <= sync1;
            if (fill != 2'd2) fill <= fill + 2'd1;
        end
    end

    // Effective frame settings: even prescale of at least 4, data length clamped to 5..DATA_WIDTH.
    always_comb begin
        ps_even = Prescale & ~PRESCALE_W'(1);
        ps_eff  = (ps_even < PRESCALE_W'(4)) ? PRESCALE_W'(4) : ps_even;
        if (Data_len < 4'd5)                    dl_eff = 4'd5;
        else if (Data_len > 4'(DATA_WIDTH))     dl_eff = 4'(DATA_WIDTH);
        else                                    dl_eff = Data_len;
    end

    // Sample-point decode and 2-of-3 vote using the live third sample.
    always_comb begin
        half      = ps_lat >> 1;
        at_a      = (cnt == half - PRESCALE_W'(1));
        at_b      = (cnt == half);
        at_maj    = (cnt == half + PRESCALE_W'(1));
        bit_end   = (cnt == ps_lat - PRESCALE_W'(1));
        maj       = (samp_a & samp_b) | (samp_a & sync2) | (samp_b & sync2);
        start_det = (state == IDLE) && armed && !sync2;
        last_data = (bit_idx == dl_lat - 4'd1);
        last_stop = (stop_idx == stop2_lat);
        fin       = (state == STOP) && at_maj && last_stop;
    end

    // State register.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (start_det) next_state = START;
            START:   if (at_maj && maj) next_state = IDLE;
                     else if (bit_end)  next_state = DATA;
            DATA:    if (bit_end && last_data) next_state = pen_lat ? PARITY : STOP;
            PARITY:  if (bit_end) next_state = STOP;
            STOP:    if (fin) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath: bit timing, shifting, frame flags and result pulses.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            armed        <= 1'b0;
            cnt          <= '0;
            ps_lat       <= PRESCALE_W'(4);
            dl_lat       <= 4'd5;
            pen_lat      <= 1'b0;
            ptype_lat    <= 1'b0;
            stop2_lat    <= 1'b0;
            bit_idx      <= 4'd0;
            stop_idx     <= 1'b0;
            samp_a       <= 1'b1;
            samp_b       <= 1'b1;
            data_sr      <= '0;
            par_acc      <= 1'b0;
            perr         <= 1'b0;
            serr         <= 1'b0;
            all_zero     <= 1'b0;
            P_Data       <= '0;
            Data_valid   <= 1'b0;
            Parity_error <= 1'b0;
            stop_error   <= 1'b0;
            Break        <= 1'b0;
        end else begin
            Data_valid   <= 1'b0;
            Parity_error <= 1'b0;
            stop_error   <= 1'b0;
            Break        <= 1'b0;
            if (start_det) begin
                // Detection already sees the first post-edge sample, so the count starts at 2.
                armed     <= 1'b0;
                ps_lat    <= ps_eff;
                dl_lat    <= dl_eff;
                pen_lat   <= Parity_EN;
                ptype_lat <= Parity_type;
                stop2_lat <= Stop_bits;
                cnt       <= PRESCALE_W'(2);
                samp_a    <= sync2;
                bit_idx   <= 4'd0;
                stop_idx  <= 1'b0;
                data_sr   <= '0;
                par_acc   <= 1'b0;
                perr      <= 1'b0;
                serr      <= 1'b0;
                all_zero  <= 1'b1;
            end else if (state == START || state == DATA || state == PARITY || state == STOP) begin
                cnt <= bit_end ? '0 : cnt + PRESCALE_W'(1);
                if (at_a) samp_a <= sync2;
                if (at_b) samp_b <= sync2;
                if (at_maj) begin
                    unique case (state)
                        DATA: begin
                            data_sr <= data_sr | (DATA_WIDTH'(maj) << bit_idx);
                            par_acc <= par_acc ^ maj;
                            if (maj) all_zero <= 1'b0;
                        end
                        PARITY: begin
                            perr <= par_acc ^ maj ^ ptype_lat;
                            if (maj) all_zero <= 1'b0;
                        end
                        STOP: begin
                            if (!maj) serr <= 1'b1;
                            else      all_zero <= 1'b0;
                        end
                        default: ;
                    endcase
                end
                if (bit_end && state == DATA) bit_idx <= bit_idx + 4'd1;
                if (bit_end && state == STOP) stop_idx <= 1'b1;
                if (fin) begin
                    // A high final stop sample lets a start edge in the rest of the stop bit count.
                    armed <= maj;
                    if (BREAK_EN && all_zero && !maj) begin
                        Break <= 1'b1;
                    end else begin
                        Parity_error <= perr;
                        stop_error   <= serr | !maj;
                        if (!perr && maj && !serr) begin
                            Data_valid <= 1'b1;
                            P_Data     <= data_sr;
                        end
                    end
                end
            end else begin
                cnt <= '0;
                if (state == IDLE && fill == 2'd2 && sync2) armed <= 1'b1;
            end
        end
    end

endmodule
